// File: rtl/scalar_fetch_unit.sv
// Scalar fetch stage: drives the program counter, issues one fetch at a time and buffers {pc, instr} for the decoder.
// Optional starvation counter output perf_starve is enabled by defining FETCH_PERF_CNT_EN.
module scalar_fetch_unit #(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [7:0]         pc_cur,
    output logic               inc_pc,
    output logic               set_pc,
    output logic [7:0]         pc_load,
    input  logic               redirect_valid,
    input  logic [7:0]         redirect_pc,
    output logic               mem_req,
    output logic [7:0]         mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [7:0]         dec_pc,
    output logic [INSTR_W-1:0] dec_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        perf_starve
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t             r_state;
    logic [7:0]         r_addr;
    logic               r_inc_pc;
    logic               r_set_pc;
    logic [7:0]         r_pc_load;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic [7:0]         r_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];

    logic               w_push;
    logic               w_pop;
    logic               w_space;
    logic               w_slot_left;
    logic [AW:0]        w_count_after_push;

    // The flush wins over any push or pop in a redirect cycle.
    assign w_push  = (r_state == WAIT) && mem_rvalid && !redirect_valid;
    assign w_pop   = (r_count != '0) && dec_ready && !redirect_valid;
    assign w_space = r_count < (AW+1)'(DEPTH);
    assign w_count_after_push = r_count - (AW+1)'(w_pop) + (AW+1)'(1);
    assign w_slot_left        = w_count_after_push < (AW+1)'(DEPTH);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_addr    <= 8'h00;
            r_inc_pc  <= 1'b0;
            r_set_pc  <= 1'b0;
            r_pc_load <= 8'h00;
        end else begin
            r_inc_pc  <= 1'b0;
            r_set_pc  <= redirect_valid;
            r_pc_load <= redirect_valid ? redirect_pc : 8'h00;
            if (redirect_valid) begin
                // A granted request still owes a response, which DROP absorbs.
                case (r_state)
                    REQ:     r_state <= mem_gnt ? DROP : IDLE;
                    WAIT:    r_state <= mem_rvalid ? IDLE : DROP;
                    DROP:    r_state <= mem_rvalid ? IDLE : DROP;
                    default: r_state <= IDLE;
                endcase
            end else begin
                case (r_state)
                    IDLE: if (w_space) r_state <= REQ;
                    REQ: if (mem_gnt) begin
                        r_state  <= WAIT;
                        r_addr   <= pc_cur;
                        r_inc_pc <= 1'b1;
                    end
                    WAIT: if (mem_rvalid) r_state <= w_slot_left ? REQ : IDLE;
                    DROP: if (mem_rvalid) r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_addr;
            r_instr_mem[r_wr_ptr] <= mem_rdata;
        end
    end

    assign inc_pc    = r_inc_pc;
    assign set_pc    = r_set_pc;
    assign pc_load   = r_pc_load;
    assign mem_req   = (r_state == REQ);
    assign mem_addr  = (r_state == REQ) ? pc_cur : r_addr;
    assign dec_valid = (r_count != '0);
    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign dec_pc    = dec_valid ? r_pc_mem[r_rd_ptr] : 8'h00;
    assign dec_instr = dec_valid ? r_instr_mem[r_rd_ptr] : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_perf;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_perf <= 16'h0000;
        end else if (redirect_valid) begin
            r_perf <= 16'h0000;
        end else if (dec_ready && !dec_valid && (r_perf != 16'hFFFF)) begin
            r_perf <= r_perf + 16'h0001;
        end
    end

    assign perf_starve = r_perf;
`endif

endmodule

// File: tb/tb_scalar_fetch_unit.sv
// Scoreboard bench for scalar_fetch_unit with a program-counter model and a latency-configurable memory model.
module tb_scalar_fetch_unit;

    localparam int DEPTH   = 4;
    localparam int INSTR_W = 32;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic [7:0]         pc_cur;
    logic               inc_pc, set_pc;
    logic [7:0]         pc_load;
    logic               redirect_valid = 1'b0;
    logic [7:0]         redirect_pc = 8'h00;
    logic               mem_req;
    logic [7:0]         mem_addr;
    logic               mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [INSTR_W-1:0] mem_rdata = '0;
    logic               dec_valid;
    logic               dec_ready = 1'b0;
    logic [7:0]         dec_pc;
    logic [INSTR_W-1:0] dec_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]        perf_starve;
`endif

    scalar_fetch_unit #(.DEPTH(DEPTH), .INSTR_W(INSTR_W)) dut (
        .clock(clock), .reset_n(reset_n), .pc_cur(pc_cur),
        .inc_pc(inc_pc), .set_pc(set_pc), .pc_load(pc_load),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_instr(dec_instr)
`ifdef FETCH_PERF_CNT_EN
        , .perf_starve(perf_starve)
`endif
    );

    always #5 clock = ~clock;

    // Upstream program counter: INC_PC has priority over SET_PC.
    logic [7:0] r_pc_model;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    r_pc_model <= 8'h00;
        else if (inc_pc) r_pc_model <= r_pc_model + 8'h04;
        else if (set_pc) r_pc_model <= pc_load;
    end
    assign pc_cur = r_pc_model;

    typedef struct packed {
        logic [7:0]         pc;
        logic [INSTR_W-1:0] instr;
    } ent_t;

    ent_t       sb_q[$];
    logic [7:0] popped[$];

    int checks = 0;
    int errors = 0;

    bit         drv_redir = 0, drv_rdy = 0, drv_stray = 0;
    logic [7:0] drv_rpc = 8'h00;
    bit         redir_on_gnt = 0, redir_in_wait = 0;
    logic [7:0] trig_rpc = 8'h00;
    int         redir_mark = 0;

    int         gnt_lat = 1, rv_lat = 1, req_age = 0;
    bit         out_busy = 0, out_drop = 0;
    int         out_cd = 0;
    logic [7:0] out_pc = 8'h00;

    bit         exp_inc = 0, exp_set = 0;
    logic [7:0] exp_load = 8'h00;
    int         perf_model = 0;
    int         n_grants = 0, n_inc = 0, n_set = 0, n_req = 0, n_drop = 0;

    function automatic logic [INSTR_W-1:0] instr_of(input logic [7:0] a);
        return {a ^ 8'h5A, ~a, a, 8'hC3};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_inc_pc"},    inc_pc,    0);
        check_eq({tag, "_set_pc"},    set_pc,    0);
        check_eq({tag, "_pc_load"},   pc_load,   0);
        check_eq({tag, "_mem_req"},   mem_req,   0);
        check_eq({tag, "_mem_addr"},  mem_addr,  0);
        check_eq({tag, "_dec_valid"}, dec_valid, 0);
        check_eq({tag, "_dec_pc"},    dec_pc,    0);
        check_eq({tag, "_dec_instr"}, dec_instr, 0);
`ifdef FETCH_PERF_CNT_EN
        check_eq({tag, "_perf"},      perf_starve, 0);
`endif
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs, advance the models.
    task automatic cyc();
        bit         resp_now;
        bit         resp_drop;
        logic [7:0] resp_pc;
        resp_now  = 0;
        resp_drop = 0;
        resp_pc   = 8'h00;
        @(negedge clock);
        redirect_valid = drv_redir;
        redirect_pc    = drv_rpc;
        dec_ready      = drv_rdy;
        mem_gnt        = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = '0;
        if (out_busy) begin
            if (out_cd == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = instr_of(out_pc);
                resp_now   = 1;
                resp_pc    = out_pc;
                resp_drop  = out_drop;
                out_busy   = 0;
            end else begin
                out_cd--;
            end
        end else if (drv_stray) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEADBEEF;
        end
        if (mem_req) begin
            if (req_age >= gnt_lat) begin
                mem_gnt = 1'b1;
                req_age = 0;
            end else begin
                req_age++;
            end
        end else begin
            req_age = 0;
        end
        if ((redir_on_gnt && mem_gnt) || (redir_in_wait && out_busy && !mem_gnt)) begin
            redirect_valid = 1'b1;
            redirect_pc    = trig_rpc;
            redir_on_gnt   = 0;
            redir_in_wait  = 0;
            redir_mark     = popped.size();
        end

        check_eq("set_pc", set_pc, exp_set);
        if (exp_set) check_eq("pc_load", pc_load, exp_load);
        check_eq("inc_pc", inc_pc, exp_inc);
        check_eq("dec_valid", dec_valid, sb_q.size() != 0);
        if (sb_q.size() != 0) begin
            check_eq("dec_pc", dec_pc, sb_q[0].pc);
            check_eq("dec_instr", dec_instr, sb_q[0].instr);
        end
        if (mem_gnt) check_eq("mem_addr", mem_addr, r_pc_model);
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_starve", perf_starve, perf_model);
`endif
        n_inc += int'(inc_pc);
        n_set += int'(set_pc);
        n_req += int'(mem_req);

        exp_set  = redirect_valid;
        exp_load = redirect_pc;
        exp_inc  = mem_gnt && !redirect_valid;
        if (redirect_valid)                                    perf_model = 0;
        else if (dec_ready && sb_q.size() == 0 && perf_model < 65535) perf_model++;
        if (mem_gnt) begin
            out_busy = 1;
            out_cd   = rv_lat - 1;
            out_pc   = r_pc_model;
            out_drop = redirect_valid;
            n_grants++;
        end else if (out_busy && redirect_valid) begin
            out_drop = 1;
        end
        if (redirect_valid) begin
            sb_q.delete();
        end else if (sb_q.size() != 0 && dec_ready) begin
            popped.push_back(sb_q[0].pc);
            void'(sb_q.pop_front());
        end
        if (resp_now) begin
            if (resp_drop || redirect_valid) n_drop++;
            else sb_q.push_back('{pc: resp_pc, instr: instr_of(resp_pc)});
        end
    endtask

    task automatic run_until_popped(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (popped.size() < n && k < budget) begin
            cyc();
            k++;
        end
        check_eq({tag, "_done"}, popped.size() >= n, 1);
    endtask

    initial begin
        int p0, g0, r0, d0, k, m;

        repeat (2) @(negedge clock);
        check_zero("reset");
        reset_n = 1'b1;

        // Straight-line fetch with an always-ready decoder.
        drv_rdy = 1;
        run_until_popped(3, 60, "straight");
        if (popped.size() >= 3) begin
            check_eq("straight_pc0", popped[0], 8'h00);
            check_eq("straight_pc1", popped[1], 8'h04);
            check_eq("straight_pc2", popped[2], 8'h08);
        end
        check_eq("straight_no_set", n_set, 0);
        check_eq("straight_inc_per_gnt", n_inc + int'(exp_inc), n_grants);

        // Backpressure: FIFO fills to DEPTH, then fetching stops.
        drv_rdy = 0;
        repeat (40) cyc();
        check_eq("bp_fill", sb_q.size(), DEPTH);
        r0 = n_req;
        repeat (10) cyc();
        check_eq("bp_no_req", n_req - r0, 0);
        drv_rdy = 1;
        p0 = popped.size();
        g0 = n_grants;
        cyc();
        drv_rdy = 0;
        repeat (15) cyc();
        check_eq("bp_one_pop", popped.size() - p0, 1);
        check_eq("bp_one_req", n_grants - g0, 1);
        check_eq("bp_refill", sb_q.size(), DEPTH);

        // Redirect while a request is outstanding.
        rv_lat = 3;
        drv_rdy = 1;
        trig_rpc = 8'h40;
        d0 = n_drop;
        redir_in_wait = 1;
        k = 0;
        while (redir_in_wait && k < 40) begin cyc(); k++; end
        check_eq("wait_redir_fired", redir_in_wait, 0);
        m = redir_mark;
        run_until_popped(m + 1, 60, "wait_redir");
        if (popped.size() > m) check_eq("wait_redir_pc", popped[m], 8'h40);
        check_eq("wait_redir_drop", n_drop - d0, 1);

        // Redirect in the same cycle as a grant.
        rv_lat = 1;
        trig_rpc = 8'h80;
        d0 = n_drop;
        redir_on_gnt = 1;
        k = 0;
        while (redir_on_gnt && k < 40) begin cyc(); k++; end
        check_eq("gnt_redir_fired", redir_on_gnt, 0);
        m = redir_mark;
        run_until_popped(m + 1, 60, "gnt_redir");
        if (popped.size() > m) check_eq("gnt_redir_pc", popped[m], 8'h80);
        check_eq("gnt_redir_drop", n_drop - d0, 1);

        // Address wrap through 0xFC.
        drv_redir = 1;
        drv_rpc = 8'hFC;
        cyc();
        drv_redir = 0;
        m = popped.size();
        run_until_popped(m + 2, 60, "wrap");
        if (popped.size() > m + 1) begin
            check_eq("wrap_pc0", popped[m], 8'hFC);
            check_eq("wrap_pc1", popped[m + 1], 8'h00);
        end

        // Asynchronous reset in the middle of a wait.
        drv_rdy = 0;
        rv_lat = 4;
        k = 0;
        while (!out_busy && k < 40) begin cyc(); k++; end
        check_eq("rst_wait_reached", out_busy, 1);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_rst");
        sb_q.delete();
        out_busy = 0; out_drop = 0; req_age = 0;
        exp_inc = 0; exp_set = 0; perf_model = 0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; redirect_valid = 1'b0; dec_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_eq("rst_release_empty", dec_valid, 0);
        drv_stray = 1;
        cyc();
        drv_stray = 0;
        rv_lat = 1;
        drv_rdy = 1;
        m = popped.size();
        run_until_popped(m + 1, 60, "post_rst");
        if (popped.size() > m) check_eq("post_rst_pc", popped[m], 8'h00);

`ifdef FETCH_PERF_CNT_EN
        // Starvation counter: five empty-and-ready cycles, then cleared by a redirect.
        drv_rdy = 0;
        rv_lat = 10;
        drv_redir = 1;
        drv_rpc = 8'h20;
        cyc();
        drv_redir = 0;
        drv_rdy = 1;
        repeat (5) cyc();
        drv_rdy = 0;
        cyc();
        check_eq("perf_five", perf_starve, 5);
        drv_redir = 1;
        cyc();
        drv_redir = 0;
        cyc();
        check_eq("perf_cleared", perf_starve, 0);
        rv_lat = 1;
`endif

        drv_rdy = 1;
        repeat (30) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
